// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the PC register, handshakes with instruction memory,
// buffers one instruction for decode. Optional misaligned-fetch trap: FETCH_MISALIGN_TRAP_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        dec_ready,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        fault_q, fault_d;
    logic        misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign    = (pc_cur[1:0] != 2'b00);
    assign fetch_fault = fault_q;
`else
    assign misalign    = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign imem_req   = (state_q == ST_FETCH) && !misalign;
    assign imem_addr  = pc_cur;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        fault_d      = fault_q;
        pc_next      = pc_cur;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redirect_valid) pc_next = redirect_pc;
            end
            ST_FETCH: begin
                if (misalign) begin
                    // A redirect wins over raising the trap for the bad PC
                    if (redirect_valid) begin
                        pc_next      = redirect_pc;
                        pend_valid_d = 1'b0;
                    end else begin
                        inst_valid_d = 1'b1;
                        inst_d       = 32'h0000_0000;
                        inst_pc_d    = pc_cur;
                        fault_d      = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end else if (imem_ack) begin
                    pend_valid_d = 1'b0;
                    if (redirect_valid) begin
                        pc_next = redirect_pc;
                    end else if (pend_valid_q) begin
                        pc_next = pend_pc_q;
                    end else begin
                        inst_valid_d = 1'b1;
                        inst_d       = imem_rdata;
                        inst_pc_d    = pc_cur;
                        pc_next      = pc_cur + PC_STEP;
                        state_d      = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Address must stay put until ack; remember where to go afterwards
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redirect_pc;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) pc_next = redirect_pc;
                if (redirect_valid || dec_ready) begin
                    inst_valid_d = 1'b0;
                    fault_d      = 1'b0;
                    state_d      = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) pc_next = pc_cur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            fault_q      <= fault_d;
        end
    end

    // The PC register and this stage must agree on the reset PC
    pc_reset_match: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_IDLE) |-> (pc_cur == RESET_PC));

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: PC register and variable-latency memory around the DUT,
// transaction-level reference model checked every cycle, plus directed literal checks.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur, pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        inst_valid, dec_ready, fetch_fault;
    logic [31:0] inst, inst_pc;

    int checks = 0;
    int errors = 0;

    inst_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .dec_ready(dec_ready), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // PC register without enable
    always @(posedge clk or posedge reset) begin
        if (reset) pc_cur <= RESET_PC;
        else       pc_cur <= pc_next;
    end

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a single-entry delivered-instruction buffer, a pending
    // redirect target, and the program-order PC the next delivery must carry.
    bit          m_first;
    bit          m_bv, m_bfault;
    logic [31:0] m_bpc, m_binst;
    bit          m_pend;
    logic [31:0] m_pend_pc, m_expect;

    always @(negedge clk) begin
        bit          fetching, mis, deliver;
        logic [31:0] exp_next;
        if (reset) begin
            chk("rst_req", imem_req, 0);
            chk("rst_valid", inst_valid, 0);
            chk("rst_inst", inst, 0);
            chk("rst_inst_pc", inst_pc, 0);
            chk("rst_fault", fetch_fault, 0);
            chk("rst_pc_next", pc_next, pc_cur);
            m_first = 1; m_bv = 0; m_bfault = 0; m_pend = 0; m_expect = RESET_PC;
        end else begin
            fetching = !m_first && !m_bv;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis = (pc_cur[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            deliver  = 0;
            exp_next = pc_cur;
            if (!fetching) begin
                if (redirect_valid) exp_next = redirect_pc;
            end else if (mis) begin
                if (redirect_valid) exp_next = redirect_pc;
            end else if (imem_ack) begin
                if (redirect_valid)  exp_next = redirect_pc;
                else if (m_pend)     exp_next = m_pend_pc;
                else begin exp_next = pc_cur + 32'd4; deliver = 1; end
            end
            chk("req", imem_req, fetching && !mis);
            chk("pc_next", pc_next, exp_next);
            chk("inst_valid", inst_valid, m_bv);
            if (imem_req) chk("imem_addr", imem_addr, pc_cur);
            if (m_bv) begin
                chk("inst_pc", inst_pc, m_bpc);
                chk("inst", inst, m_binst);
                chk("fault", fetch_fault, m_bfault);
                if (!m_bfault) chk("inst_vs_mem", inst, mem_f(inst_pc));
            end else begin
                chk("fault_idle", fetch_fault, 0);
            end
            if (deliver) chk("stream_pc", pc_cur, m_expect);

            // advance the model to the next cycle
            if (m_first) begin
                m_first = 0;
                if (redirect_valid) m_expect = redirect_pc;
            end else if (m_bv) begin
                if (redirect_valid) m_expect = redirect_pc;
                if (redirect_valid || dec_ready) m_bv = 0;
            end else if (mis) begin
                if (redirect_valid) m_expect = redirect_pc;
                else begin m_bv = 1; m_bfault = 1; m_bpc = pc_cur; m_binst = 32'h0; end
            end else if (imem_ack) begin
                if (deliver) begin
                    m_bv = 1; m_bfault = 0; m_bpc = pc_cur; m_binst = imem_rdata;
                    m_expect = pc_cur + 32'd4;
                end
                if (redirect_valid) m_expect = redirect_pc;
                m_pend = 0;
            end else if (redirect_valid) begin
                m_pend = 1; m_pend_pc = redirect_pc; m_expect = redirect_pc;
            end
        end
    end

    // Memory responder state
    bit in_txn;
    int wait_cnt, cur_lat, lat_cfg;
    bit lat_rand;

    task automatic step(input bit rv, input logic [31:0] rpc, input bit dr);
        @(posedge clk); #1;
        reset = 1'b0;
        redirect_valid = rv; redirect_pc = rpc; dec_ready = dr;
        #1;
        if (imem_req && !in_txn) begin
            in_txn = 1; wait_cnt = 0;
            cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
        end
        imem_ack   = imem_req && (wait_cnt >= cur_lat);
        imem_rdata = imem_ack ? mem_f(imem_addr) : $urandom;
        @(negedge clk);
        if (imem_ack) in_txn = 0;
        else if (imem_req) wait_cnt++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; redirect_valid = 0; dec_ready = 0; imem_ack = 0; in_txn = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 0; redirect_pc = 0; dec_ready = 0;
        imem_ack = 0; imem_rdata = 0; in_txn = 0; wait_cnt = 0; cur_lat = 0;
        lat_cfg = 0; lat_rand = 0;
        @(negedge clk);
        chk("lit_rst_pc_next", pc_next, 32'h0);
        @(negedge clk);

        step(0, 0, 0);                              // IDLE
        chk("lit_idle_req", imem_req, 0);
        lat_cfg = 0; step(0, 0, 0);                 // ack in first FETCH cycle
        chk("lit_req0", imem_req, 1);
        chk("lit_addr0", imem_addr, 32'h0);
        chk("lit_pc_next0", pc_next, 32'h4);
        lat_cfg = 3; step(0, 0, 1);                 // HOLD, accepted
        chk("lit_valid0", inst_valid, 1);
        chk("lit_inst0", inst, 32'h0050_0093);
        chk("lit_inst_pc0", inst_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin           // three wait cycles at 0x4
            step(0, 0, 0);
            chk("lit_wait_addr", imem_addr, 32'h4);
            chk("lit_wait_pc_next", pc_next, 32'h4);
            chk("lit_wait_ack", imem_ack, 0);
        end
        step(0, 0, 0);                              // ack at 0x4
        chk("lit_pc_next4", pc_next, 32'h8);
        for (int i = 0; i < 5; i++) begin           // decode stalled
            step(0, 0, 0);
            chk("lit_stall_inst_pc", inst_pc, 32'h4);
            chk("lit_stall_req", imem_req, 0);
            chk("lit_stall_pc_next", pc_next, 32'h8);
        end
        step(0, 0, 1);
        chk("lit_accept6_valid", inst_valid, 1);
        lat_cfg = 2; step(1, 32'h100, 0);           // redirect two cycles before ack
        chk("lit_redir_hold_pc", pc_next, 32'h8);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("lit_stale_ack", imem_ack, 1);
        chk("lit_stale_pc_next", pc_next, 32'h100);
        lat_cfg = 0; step(1, 32'h200, 0);           // redirect together with ack
        chk("lit_drop_valid", inst_valid, 0);
        chk("lit_addr100", imem_addr, 32'h100);
        chk("lit_pc_next200", pc_next, 32'h200);
        step(0, 0, 0);
        chk("lit_addr200", imem_addr, 32'h200);
        step(1, 32'h300, 1);                        // redirect in HOLD with dec_ready
        chk("lit_hold200", inst_pc, 32'h200);
        chk("lit_pc_next300", pc_next, 32'h300);
        step(0, 0, 0);
        chk("lit_flushed", inst_valid, 0);
        chk("lit_addr300", imem_addr, 32'h300);
        step(1, 32'h102, 1);
        chk("lit_pc_next102", pc_next, 32'h102);
        step(0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("lit_mis_req", imem_req, 0);
        step(0, 0, 1);
        chk("lit_mis_fault", fetch_fault, 1);
        chk("lit_mis_valid", inst_valid, 1);
        chk("lit_mis_inst_pc", inst_pc, 32'h102);
        chk("lit_mis_inst", inst, 32'h0);
`else
        chk("lit_mis_req", imem_req, 1);
        chk("lit_mis_addr", imem_addr, 32'h102);
        step(0, 0, 1);
        chk("lit_mis_fault", fetch_fault, 0);
        chk("lit_mis_inst_pc", inst_pc, 32'h102);
`endif
        step(1, 32'h400, 0);

        lat_rand = 1;
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] rpc;
            rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            rpc = rpc[31:0];
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            if ($urandom_range(0, 700) == 0) do_reset();
            step($urandom_range(0, 7) == 0, rpc, $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage of the CPU Lab core. It sits between the PC register and instruction memory, and feeds the IF/ID boundary.
- It drives the PC register's next-value input every cycle. The PC register has no enable, so stalls are done by feeding the current PC back.
- It runs a req/ack handshake with instruction memory, which may have variable latency.
- It holds one fetched instruction until decode accepts it, and it accepts control-flow redirects at any time.

Parameters:
- RESET_PC, 32'h00000000: PC value after reset. Must equal the PC register's reset value.
- PC_STEP, 4: sequential PC increment, in bytes.

Ports:
- clk  in  1: clock. All state updates on posedge.
- reset  in  1: asynchronous, active-high reset.
- pc_cur  in  32: current PC, from the PC register output.
- pc_next  out  32: next PC, to the PC register input. Combinational.
- redirect_valid  in  1: branch/jump taken this cycle.
- redirect_pc  in  32: redirect target.
- imem_req  out  1: memory request.
- imem_addr  out  32: request address.
- imem_ack  in  1: data valid this cycle; completes the request.
- imem_rdata  in  32: instruction word.
- inst_valid  out  1: the instruction buffer holds a valid instruction.
- inst  out  32: buffered instruction.
- inst_pc  out  32: PC of the buffered instruction.
- dec_ready  in  1: decode accepts the instruction this cycle.
- fetch_fault  out  1: misaligned-fetch flag (see Optional Feature).

Behaviour:
- Reset (async) forces the following:
  - state = IDLE.
  - imem_req = 0.
  - inst_valid = 0, inst = 0, inst_pc = 0.
  - pend_valid = 0, pend_pc = 0.
  - fetch_fault = 0.
  - pc_next = pc_cur.
- Reset asserted mid-request abandons the transaction. The memory must tolerate req dropping without ack.
- States:
  - IDLE: one cycle after reset, then go to FETCH.
  - FETCH: request in flight.
  - HOLD: instruction buffered, waiting for decode.
- FETCH:
  - imem_req = 1 and imem_addr = pc_cur.
  - pc_cur must stay stable until ack, so pc_next = pc_cur while no ack.
  - Ack with no pending or current redirect: capture inst = imem_rdata and inst_pc = pc_cur; set inst_valid = 1; pc_next = pc_cur + PC_STEP (mod 2^32, wrap allowed); go to HOLD.
  - Minimum latency from request to inst_valid is 1 cycle (ack in the first FETCH cycle).
- Redirect in FETCH without ack: latch pend_pc = redirect_pc and set pend_valid = 1. pc_next stays pc_cur, so the address is held. A later redirect overwrites pend_pc (last wins).
- Ack with pend_valid set: discard the data; pc_next = pend_pc; clear pend_valid; stay in FETCH. The new request issues the next cycle.
- Ack and redirect_valid in the same cycle: discard the data; pc_next = redirect_pc; stay in FETCH. The current redirect has priority over pend_pc; clear pend_valid.
- imem_req stays high across back-to-back requests. Each ack cycle ends one transaction.
- HOLD:
  - imem_req = 0; pc_next = pc_cur.
  - dec_ready: clear inst_valid next cycle and go to FETCH.
  - No dec_ready: inst, inst_pc and inst_valid stay stable.
- Redirect in HOLD: pc_next = redirect_pc; inst_valid cleared next cycle (buffered instruction flushed even if dec_ready); go to FETCH.
- Redirect in IDLE: pc_next = redirect_pc; go to FETCH.
- Throughput: at most one instruction per 2 cycles. No speculative prefetch.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined, in FETCH with pc_cur[1:0] != 0:
  - No request is issued.
  - fetch_fault = 1, inst_valid = 1, inst = 32'h00000000, inst_pc = pc_cur.
  - Go to HOLD.
  - fetch_fault clears together with inst_valid (on dec_ready or redirect).
- When undefined: fetch_fault is tied 0. Misaligned PCs are fetched as-is with imem_addr = pc_cur.

Test Plan:
- Reset, then ack with 1-cycle latency, rdata 32'h00500093, dec_ready = 1 → inst_valid on the cycle after ack with inst_pc = 0x0; pc_next = 0x4 in the ack cycle; next request address = 0x4.
- Ack delayed 3 cycles → imem_addr held at 0x4 and pc_next = 0x4 for all wait cycles; inst_pc = 0x4.
- dec_ready low 5 cycles in HOLD → inst/inst_pc stable, imem_req = 0, pc_next = pc_cur; accepted on the 6th cycle.
- Redirect to 0x100 two cycles before ack at 0x8 → ack data discarded, inst_valid stays 0, next request at 0x100.
- Redirect to 0x200 together with ack, and redirect to 0x300 in HOLD with dec_ready = 1 → data dropped, pc_next = 0x200; HOLD instruction flushed, next fetch at 0x300.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 → no imem_req, fetch_fault = 1, inst_pc = 0x102; without the macro, request at 0x102 and fetch_fault = 0.
